// File: rtl/calc_pkg.sv
// Shared definitions for the keypad front end and the calculator core:
// key code meanings, scan FSM encoding and small keypad helpers.
package calc_pkg;

  localparam logic [3:0] KEY_EQ  = 4'd10;
  localparam logic [3:0] KEY_CLR = 4'd11;
  localparam logic [3:0] KEY_ADD = 4'd12;
  localparam logic [3:0] KEY_SUB = 4'd13;
  localparam logic [3:0] KEY_MUL = 4'd14;
  localparam logic [3:0] KEY_DIV = 4'd15;

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    PRESS    = 3'd2,
    HOLD     = 3'd3,
    RELEASE  = 3'd4
  } scan_state_t;

  // Code is 4*row + column, which is simply the two indices concatenated.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

  // Lowest-numbered low column wins when several keys share a row.
  function automatic logic [1:0] low_col(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Exactly one row driven low.
  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column inputs.
// Resets to all-high so an idle (pulled-up) keypad is seen during reset.
module col_sync (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] col_i,
  output logic [3:0] col_s_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Two-stage capture of the raw column pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= col_i;
      sync_q <= meta_q;
    end
  end

  assign col_s_o = sync_q;

endmodule

// File: rtl/key_scan_ctrl.sv
// Keypad scanner: rotates a low row drive, debounces the first key found,
// emits one flag pulse per press and holds off until a debounced release.
//
// state    | meaning
// ---------+----------------------------------------------------------
// SCAN     | drive current row for the dwell time, sample on last cycle
// DEBOUNCE | row frozen, count stable-low cycles of the latched column
// PRESS    | one-cycle flag with the key code
// HOLD     | row frozen, wait for all columns high
// RELEASE  | count stable all-high cycles, then resume scanning
module key_scan_ctrl
  import calc_pkg::*;
#(
  parameter int SCAN_DWELL   = 4,
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic       clk_1khz,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] data,
  output logic       flag,
  output logic       key_held
);

  localparam int CNT_MAX = (SCAN_DWELL > DEBOUNCE_CYC) ? SCAN_DWELL : DEBOUNCE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DWELL - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == CNT_SAT) ? x : x + 1'b1;
  endfunction

  logic [3:0]  col_s;
  scan_state_t state_q, state_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [3:0]  data_q, data_d;

  col_sync u_col_sync (
    .clk_i   (clk_1khz),
    .rst_i   (rst),
    .col_i   (col),
    .col_s_o (col_s)
  );

  // State, row index, latched column, counters and key code registers.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q   <= SCAN;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      dwell_q   <= '0;
      deb_q     <= '0;
      data_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      dwell_q   <= dwell_d;
      deb_q     <= deb_d;
      data_q    <= data_d;
    end
  end

  // Next-state logic; counters fall back to zero whenever they are not counting.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    dwell_d   = '0;
    deb_d     = '0;
    data_d    = data_q;

    case (state_q)
      SCAN: begin
        if (dwell_q >= DWELL_LAST) begin
          if (col_s != 4'hF) begin
            col_idx_d = low_col(col_s);
            state_d   = DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          dwell_d = sat_inc(dwell_q);
        end
      end

      DEBOUNCE: begin
        if (!col_s[col_idx_q]) begin
          if (deb_q >= DEB_LAST) begin
            state_d = PRESS;
            data_d  = key_code(row_idx_q, col_idx_q);
          end else begin
            deb_d = sat_inc(deb_q);
          end
        end else begin
          row_idx_d = row_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end

      PRESS: state_d = HOLD;

      HOLD: begin
        if (col_s == 4'hF) state_d = RELEASE;
      end

      RELEASE: begin
        if (col_s == 4'hF) begin
          if (deb_q >= DEB_LAST) begin
            state_d   = SCAN;
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            deb_d = sat_inc(deb_q);
          end
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d   = SCAN;
        row_idx_d = 2'd0;
      end
    endcase
  end

  assign row      = row_drive(row_idx_q);
  assign data     = data_q;
  assign flag     = (state_q == PRESS);
  assign key_held = (state_q == PRESS) || (state_q == HOLD) || (state_q == RELEASE);

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl with a behavioural 4x4 keypad model.
// Expected key codes are queued when a press is driven and popped on flag.
module tb_key_scan_ctrl;
  import calc_pkg::*;

  logic        clk_1khz = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  data;
  logic        flag;
  logic        key_held;

  logic [15:0] keys;
  logic        force_en;
  logic [3:0]  force_val;

  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  logic        prev_flag;
  int          total = 0;
  int          bad   = 0;
  bit          got;

  key_scan_ctrl #(.SCAN_DWELL(4), .DEBOUNCE_CYC(20)) dut (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .data     (data),
    .flag     (flag),
    .key_held (key_held)
  );

  always #5 clk_1khz = ~clk_1khz;

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[4*r+c]) col[c] = 1'b0;
        end
      end
    end
    if (force_en) col = force_val;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_flag(input int lim, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      if (flag === 1'b1) seen = 1'b1;
      else tick(1);
    end
  endtask

  task automatic wait_idle(input int lim, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      if (key_held === 1'b0) seen = 1'b1;
      else tick(1);
    end
  endtask

  // Scoreboard and invariants, sampled on the falling edge.
  always @(negedge clk_1khz) begin
    total++;
    assert ($countones(~row) == 1) else begin
      bad++;
      $error("FAIL row_onehot observed=%b expected=one_low", row);
    end
    if (flag === 1'b1) begin
      total++;
      assert (prev_flag !== 1'b1) else begin
        bad++;
        $error("FAIL flag_width observed=two_cycles expected=one_cycle");
      end
      total++;
      assert (key_held === 1'b1) else begin
        bad++;
        $error("FAIL held_on_flag observed=%b expected=1", key_held);
      end
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_flag observed=data_%0d expected=no_flag", data);
      end
      if (exp_q.size() != 0) begin
        exp_code = exp_q.pop_front();
        total++;
        assert (data === exp_code) else begin
          bad++;
          $error("FAIL key_code observed=%0d expected=%0d", data, exp_code);
        end
      end
    end
    prev_flag = flag;
  end

  initial begin
    prev_flag = 1'b0;
    keys      = 16'h0;
    force_en  = 1'b1;
    force_val = 4'b0000;
    rst       = 1'b1;

    // Reset with every column low
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_row", 8'(row), 8'b1110);
      check("rst_flag", 8'(flag), 8'd0);
      check("rst_data", 8'(data), 8'd0);
      check("rst_held", 8'(key_held), 8'd0);
    end
    rst      = 1'b0;
    force_en = 1'b0;
    tick(3);
    check("dwell_row0", 8'(row), 8'b1110);
    tick(1);
    check("dwell_row1", 8'(row), 8'b1101);
    tick(4);
    check("dwell_row2", 8'(row), 8'b1011);

    // Single clean press at row 2, col 1
    keys = 16'h1 << 9;
    exp_q.push_back(4'd9);
    wait_flag(80, got);
    check("single_flag_seen", 8'(got), 8'd1);
    tick(1);
    check("single_flag_drop", 8'(flag), 8'd0);
    check("single_data_hold", 8'(data), 8'd9);
    tick(60);
    check("single_held", 8'(key_held), 8'd1);
    keys = 16'h0;
    tick(22);
    check("release_held_late", 8'(key_held), 8'd1);
    tick(1);
    check("release_held_drop", 8'(key_held), 8'd0);
    check("release_data_keep", 8'(data), 8'd9);
    check("single_queue", 8'(exp_q.size()), 8'd0);

    // Every key in turn
    for (int k = 0; k < 16; k++) begin
      keys = 16'h1 << k;
      exp_q.push_back(4'(k));
      wait_flag(80, got);
      check("keymap_flag_seen", 8'(got), 8'd1);
      tick(3);
      keys = 16'h0;
      wait_idle(60, got);
      check("keymap_idle", 8'(got), 8'd1);
      tick(2);
    end
    check("keymap_queue", 8'(exp_q.size()), 8'd0);

    // Short pulse is rejected, then a bouncy press is accepted once
    keys = 16'h1 << 12;
    tick(10);
    keys = 16'h0;
    tick(60);
    check("pulse_no_held", 8'(key_held), 8'd0);
    for (int i = 0; i < 5; i++) begin
      keys = 16'h1 << 12;
      tick(3);
      keys = 16'h0;
      tick(3);
    end
    keys = 16'h1 << 12;
    exp_q.push_back(KEY_ADD);
    wait_flag(80, got);
    check("bounce_flag_seen", 8'(got), 8'd1);
    tick(3);
    keys = 16'h0;
    wait_idle(60, got);
    check("bounce_idle", 8'(got), 8'd1);
    check("bounce_queue", 8'(exp_q.size()), 8'd0);

    // Rollover during hold, then a release bounce on the first key
    keys = 16'h1;
    exp_q.push_back(4'd0);
    wait_flag(80, got);
    check("roll_flag_seen", 8'(got), 8'd1);
    keys = 16'h1 | (16'h1 << 7);
    tick(30);
    check("roll_held", 8'(key_held), 8'd1);
    keys = 16'h0;
    tick(5);
    keys = 16'h1;
    tick(10);
    check("roll_bounce_held", 8'(key_held), 8'd1);
    keys = 16'h0;
    wait_idle(60, got);
    check("roll_idle", 8'(got), 8'd1);
    tick(40);
    check("roll_queue", 8'(exp_q.size()), 8'd0);

    // Reset ten cycles into debounce
    keys = 16'h1 << 5;
    got  = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (dut.state_q == DEBOUNCE) got = 1'b1;
      else tick(1);
    end
    check("mid_reach_debounce", 8'(got), 8'd1);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_row", 8'(row), 8'b1110);
    check("mid_rst_flag", 8'(flag), 8'd0);
    check("mid_rst_held", 8'(key_held), 8'd0);
    check("mid_rst_data", 8'(data), 8'd0);
    exp_q.push_back(4'd5);
    wait_flag(80, got);
    check("mid_reflag_seen", 8'(got), 8'd1);
    tick(3);
    keys = 16'h0;
    wait_idle(60, got);
    check("mid_idle", 8'(got), 8'd1);
    tick(10);
    check("final_queue", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_scan_ctrl.md
# key_scan_ctrl

Scans the 4x4 matrix keypad and turns physical key presses into the `data`/`flag` key stream consumed by the calculator state machine. It drives one keypad row low at a time and synchronizes the column inputs. Each press is debounced and emitted as one single-cycle `flag` pulse carrying a 4-bit key code. The key is then held off until it has been debounced as released. The block sits between the keypad pins and the calculator core, in the same 1 kHz clock domain.

## Interface
Parameters:
- `SCAN_DWELL`, default 4: cycles each row is driven low before its columns are sampled; legal range ≥3.
- `DEBOUNCE_CYC`, default 20: consecutive stable cycles required for press and for release (20 ms at 1 kHz); legal range ≥1.

Ports:
- `clk_1khz`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `col`  in  4: keypad columns, active-low with external pull-ups, asynchronous to the clock.
- `row`  out  4: keypad row drive, exactly one bit low.
- `data`  out  4: key code; valid when `flag`=1 and holds its value afterwards.
- `flag`  out  1: single-cycle pulse, one per debounced press.
- `key_held`  out  1: high from the `flag` cycle until the key has been debounced as released.

## Operation
- **Column synchronization.** `col` passes through a 2-FF synchronizer; `col_s` denotes its output. All decisions use `col_s` only.
- **Row order.** The drive sequence is `4'b1110`, `4'b1101`, `4'b1011`, `4'b0111`, then wraps back to `4'b1110`. Row index r = 0..3 in that order.
- **Key codes.** Column index c = position of the low bit in `col_s`, with `4'b1110` giving c=0. The code is `data` = 4*r + c.
- **Code meanings.**
  - Codes 0–9 are digits.
  - 10 is '=', 11 is clear.
  - 12 is '+', 13 is '-', 14 is '*', 15 is '/'.
- **SCAN state.**
  - The row is held for `SCAN_DWELL` cycles.
  - On the last dwell cycle, if `col_s` != `4'hF`: latch r and c, freeze `row`, go to DEBOUNCE.
  - If several columns are low, the lowest c wins.
  - Otherwise advance to the next row and restart the dwell counter.
- **DEBOUNCE state.**
  - The counter increments each cycle while `col_s[c]`=0.
  - If `col_s[c]`=1 on any cycle: clear the counter, advance to the next row, return to SCAN.
  - When the counter reaches `DEBOUNCE_CYC`, go to PRESS.
- **PRESS state.** Lasts one cycle: `flag`=1, `data`=4*r+c, `key_held`=1. Always go to HOLD next.
- **HOLD state.** `row` stays frozen. Wait for `col_s` = `4'hF`, then go to RELEASE with the counter cleared.
- **RELEASE state.**
  - The counter increments while `col_s` = `4'hF`.
  - Any low column clears the counter and returns to HOLD.
  - When the counter reaches `DEBOUNCE_CYC`: clear `key_held`, advance to the next row, go to SCAN.
- **Second key during a hold.** A second key pressed while the first is held is ignored; no `flag` is produced for it.
- **Illegal state encoding.** Go to SCAN with `row`=`4'b1110`.
- **Counter widths.** Both the dwell and debounce counters are sized $clog2(max(param)+1). They saturate and never wrap.

## Timing
- **Reset values.** While `rst`=1 at a clock edge, on the following cycle:
  - `row`=`4'b1110`, `data`=0, `flag`=0, `key_held`=0;
  - state is SCAN, all counters are 0, synchronizer flops are `4'hF`.
- **Reset mid-operation.** Reset aborts any pending press or release; no `flag` is issued for that press.
- **Press latency.** Let t be the SCAN sample cycle that detects the key. DEBOUNCE occupies t+1 .. t+`DEBOUNCE_CYC`, and `flag` is asserted in cycle t+`DEBOUNCE_CYC`+1.
- **Worst-case detection.** Detection happens ≤ 4*`SCAN_DWELL` + 2 cycles after `col` goes low, for a key already stable.
- **`flag` width.** `flag` is never high for two consecutive cycles.
- **Minimum press spacing.** The gap between two `flag` pulses is ≥ 2*`DEBOUNCE_CYC` + 3 cycles.
- **`data` stability.** `data` changes only in the PRESS cycle.
- **Row stability.** `row` changes only at a SCAN dwell boundary or when leaving DEBOUNCE/RELEASE, and always stays one-hot-low.

## Structure
- **Shared package `calc_pkg`:**
  - key code constants `KEY_EQ`=10, `KEY_CLR`=11, `KEY_ADD`=12, `KEY_SUB`=13, `KEY_MUL`=14, `KEY_DIV`=15;
  - state encoding constants SCAN=0, DEBOUNCE=1, PRESS=2, HOLD=3, RELEASE=4.
- **Sub-module `col_sync`:** a 4-bit 2-FF synchronizer with synchronous active-high reset to `4'hF`.
- **Top level:** the FSM, row rotation and counters stay in `key_scan_ctrl`.

## Test plan
All scenarios use `SCAN_DWELL`=4 and `DEBOUNCE_CYC`=20.
- **Reset values.** Assert `rst` for 3 cycles with `col`=`4'b0000` -> `row`=`4'b1110`, `flag`=0, `data`=0, `key_held`=0 throughout; scanning starts after release.
- **Single clean press.** Hold the key at row 2, col 1 for 100 cycles -> exactly one `flag` with `data`=9, `key_held` high until 21 cycles after `col` returns to `4'hF` plus sync delay.
- **Full keymap.** Press all 16 keys in turn -> codes 0..15 in order, each with exactly one `flag`.
- **Bounce rejection.**
  - 10-cycle pulse on row 3, col 0 -> no `flag`.
  - Stable press after 5 bounces of 3 cycles -> one `flag`, `data`=12.
- **Hold rollover and release bounce.** Hold row 0, col 0, then add row 1, col 3 -> one `flag` (`data`=0). Release-bounce the first key with a 5-cycle low -> no second `flag`.
- **Reset mid-DEBOUNCE.** Pulse `rst` for 1 cycle, 10 cycles into DEBOUNCE -> no `flag`, `row`=`4'b1110`. A still-held key is re-detected and flagged once.
